// File: rtl/whack_pkg.sv
// Shared constants for the whack-a-mole input path.
// Board-level defaults for hammer count, clock rate and 10 ms debounce.
package whack_pkg;

    localparam int N_HAMMER       = 5;
    localparam int CLK_HZ         = 100_000_000;
    localparam int DB_CYCLES_10MS = CLK_HZ / 100;

endpackage

// File: rtl/debounce_ch.sv
// One hammer channel: 2-flop synchroniser, stability counter, accepted
// level and a registered rising-edge flag.
module debounce_ch
    import whack_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_10MS
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          stable;
    logic [CW-1:0] cnt;

    // Any sample equal to the accepted value restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            rise   <= 1'b0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            rise <= 1'b0;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= s2;
                cnt    <= '0;
                rise   <= s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign level = stable;

endmodule

// File: rtl/hammer_conditioner.sv
// Hammer button conditioner: debounced levels plus armed, lockable hit pulses.
// Define HAMMER_ONEHOT_EN to allow only the lowest simultaneous hit to pulse.
module hammer_conditioner
    import whack_pkg::*;
#(
    parameter int N_BTN     = N_HAMMER,
    parameter int DB_CYCLES = DB_CYCLES_10MS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic [N_BTN-1:0] hammer_raw,
    output logic [N_BTN-1:0] hammer_level,
    output logic [N_BTN-1:0] hammer_pulse,
    output logic             hammer_idle
);

    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] lock;
    logic [N_BTN-1:0] cand;
    logic [N_BTN-1:0] grant;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        debounce_ch #(
            .DB_CYCLES(DB_CYCLES)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .raw  (hammer_raw[i]),
            .level(hammer_level[i]),
            .rise (rise[i])
        );
    end

    assign cand = rise & ~lock & {N_BTN{arm}};

`ifdef HAMMER_ONEHOT_EN
    // Lowest set bit wins; losers are dropped, not queued.
    assign grant = cand & (~cand + N_BTN'(1));
`else
    assign grant = cand;
`endif

    // A button held while disarmed stays locked until it is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock         <= '0;
            hammer_pulse <= '0;
        end else begin
            hammer_pulse <= grant;
            for (int i = 0; i < N_BTN; i++) begin
                if (!hammer_level[i]) begin
                    lock[i] <= 1'b0;
                end else if (!arm) begin
                    lock[i] <= 1'b1;
                end
            end
        end
    end

    assign hammer_idle = ~|hammer_level;

endmodule

// File: tb/tb_hammer_conditioner.sv
// Table-driven bench for hammer_conditioner with DB_CYCLES=4.
// Rows are one clock edge each; expectations go through a scoreboard queue.
module tb_hammer_conditioner;

    typedef struct {
        logic       rst;
        logic       arm;
        logic [4:0] raw;
        logic [4:0] lvl;
        logic [4:0] pls;
    } vec_t;

    typedef struct {
        int         row;
        logic [4:0] lvl;
        logic [4:0] pls;
        logic       idle;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       arm = 1'b0;
    logic [4:0] hammer_raw = '0;
    logic [4:0] hammer_level;
    logic [4:0] hammer_pulse;
    logic       hammer_idle;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_pass = 0;
    int   n_chk  = 0;

    hammer_conditioner #(
        .N_BTN    (5),
        .DB_CYCLES(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .arm         (arm),
        .hammer_raw  (hammer_raw),
        .hammer_level(hammer_level),
        .hammer_pulse(hammer_pulse),
        .hammer_idle (hammer_idle)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic a,
                                input logic [4:0] rw, input logic [4:0] l,
                                input logic [4:0] p, input int n);
        vec_t v;
        v.rst = r;
        v.arm = a;
        v.raw = rw;
        v.lvl = l;
        v.pls = p;
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endfunction

    // From all-zero: level on edge 6, pulse on edge 7, then held.
    function automatic void press(input logic a, input logic [4:0] b,
                                  input logic [4:0] p, input int hold);
        add(0, a, b, 5'b0, 5'b0, 5);
        add(0, a, b, b, 5'b0, 1);
        add(0, a, b, b, p, 1);
        add(0, a, b, b, 5'b0, hold);
    endfunction

    // Release of held bits b; level drops on edge 6, never pulses.
    function automatic void release_all(input logic a, input logic [4:0] b);
        add(0, a, 5'b0, b, 5'b0, 5);
        add(0, a, 5'b0, 5'b0, 5'b0, 3);
    endfunction

    task automatic check(input string nm, input int row,
                         input logic [4:0] act, input logic [4:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s row %0d: got %b expected %b", nm, row, act, exp);
    endtask

    initial begin
        exp_t e;
        logic [4:0] sim;
`ifdef HAMMER_ONEHOT_EN
        sim = 5'b01000;
`else
        sim = 5'b11000;
`endif
        // Reset with all pins high, then a partial count killed by reset.
        add(1, 0, 5'b11111, 5'b0, 5'b0, 3);
        add(0, 0, 5'b11111, 5'b0, 5'b0, 4);
        add(1, 0, 5'b11111, 5'b0, 5'b0, 1);
        press(0, 5'b11111, 5'b0, 1);
        release_all(0, 5'b11111);
        // Clean press on channel 2, held with no repeat.
        press(1, 5'b00100, 5'b00100, 3);
        release_all(1, 5'b00100);
        // Bounce on channel 0: high 3, low 1, then held.
        add(0, 1, 5'b00001, 5'b0, 5'b0, 3);
        add(0, 1, 5'b00000, 5'b0, 5'b0, 1);
        add(0, 1, 5'b00001, 5'b0, 5'b0, 5);
        add(0, 1, 5'b00001, 5'b00001, 5'b0, 1);
        add(0, 1, 5'b00001, 5'b00001, 5'b00001, 1);
        add(0, 1, 5'b00001, 5'b00001, 5'b0, 2);
        release_all(1, 5'b00001);
        // Arm lock: held while disarmed, then armed, then re-pressed.
        press(0, 5'b00010, 5'b0, 1);
        add(0, 1, 5'b00010, 5'b00010, 5'b0, 4);
        release_all(1, 5'b00010);
        press(1, 5'b00010, 5'b00010, 1);
        release_all(1, 5'b00010);
        // Simultaneous rises on channels 4 and 3.
        press(1, 5'b11000, sim, 1);
        release_all(1, 5'b11000);
        // Disarm mid-press: level tracks, pulse suppressed.
        add(0, 1, 5'b00100, 5'b0, 5'b0, 3);
        add(0, 0, 5'b00100, 5'b0, 5'b0, 2);
        add(0, 0, 5'b00100, 5'b00100, 5'b0, 4);
        release_all(0, 5'b00100);
        // Re-armed after a disarmed hold: next press pulses.
        press(1, 5'b00100, 5'b00100, 1);
        release_all(1, 5'b00100);

        for (int r = 0; r < tbl.size(); r++) begin
            rst        = tbl[r].rst;
            arm        = tbl[r].arm;
            hammer_raw = tbl[r].raw;
            e.row  = r;
            e.lvl  = tbl[r].lvl;
            e.pls  = tbl[r].pls;
            e.idle = ~|tbl[r].lvl;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check("level", e.row, hammer_level, e.lvl);
            check("pulse", e.row, hammer_pulse, e.pls);
            check("idle", e.row, {4'b0, hammer_idle}, {4'b0, e.idle});
        end
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL scoreboard: %0d left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
